// File: rtl/fft_bitrev_loader.sv
// rtl/fft_bitrev_loader.sv - bit-reversed reorder buffer feeding an FFT stage.
// One frame is stored with bit-reversed write addresses, then drained in natural address order.
module fft_bitrev_loader #(
  parameter int N       = 32,
  parameter int PTS     = 8,
  parameter int LOG2PTS = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_last
);

  typedef enum logic {FILL, DRAIN} state_t;

  localparam logic [LOG2PTS-1:0] LAST = LOG2PTS'(PTS - 1);

  state_t             state, state_next;
  logic [LOG2PTS-1:0] wr_cnt, wr_cnt_next;
  logic [LOG2PTS-1:0] rd_cnt, rd_cnt_next;
  logic               live;
  logic               in_xfer, out_xfer;
  logic [N-1:0]       mem [PTS];

  function automatic logic [LOG2PTS-1:0] bitrev(input logic [LOG2PTS-1:0] a);
    logic [LOG2PTS-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2PTS; i++) r[i] = a[LOG2PTS-1-i];
    return r;
  endfunction

  // live holds in_ready low until the first edge after reset is released
  always_ff @(posedge clk or posedge reset) begin
    if (reset) live <= 1'b0;
    else       live <= 1'b1;
  end

  assign in_ready  = (state == FILL) && live;
  assign out_valid = (state == DRAIN);
  assign in_xfer   = in_valid && in_ready && !flush;
  assign out_xfer  = out_valid && out_ready && !flush;

  always_comb begin
    out_data = '0;
    out_last = 1'b0;
    if (out_valid) begin
      out_data = mem[rd_cnt];
      out_last = (rd_cnt == LAST);
    end
  end

  always_comb begin
    state_next  = state;
    wr_cnt_next = wr_cnt;
    rd_cnt_next = rd_cnt;
    case (state)
      FILL: begin
        if (in_xfer) begin
          wr_cnt_next = wr_cnt + 1'b1;
          if (wr_cnt == LAST) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (out_xfer) begin
          rd_cnt_next = rd_cnt + 1'b1;
          if (rd_cnt == LAST) state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
    if (flush) begin
      state_next  = FILL;
      wr_cnt_next = '0;
      rd_cnt_next = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= FILL;
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      state  <= state_next;
      wr_cnt <= wr_cnt_next;
      rd_cnt <= rd_cnt_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PTS; i++) mem[i] <= '0;
    end else if (in_xfer) begin
      mem[bitrev(wr_cnt)] <= in_data;
    end
  end

endmodule

// File: tb/tb_fft_bitrev_loader.sv
// tb/tb_fft_bitrev_loader.sv - self-checking bench for fft_bitrev_loader.
// A queue-based frame model is checked every cycle; literal vectors pin the model.
module tb_fft_bitrev_loader;
  localparam int N = 32, PTS = 8, LOG2 = 3;

  logic clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 1;
  logic [N-1:0] in_data = '0;
  logic in_ready, out_valid, out_last;
  logic [N-1:0] out_data;

  fft_bitrev_loader #(.N(N), .PTS(PTS), .LOG2PTS(LOG2)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last));

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic int rev(input int k);
    int r = 0;
    int v = k;
    for (int b = 0; b < LOG2; b++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  // Behavioural model: collect a frame, then emit it in bit-reversed index order
  logic [N-1:0] m_fill[$];
  logic [N-1:0] m_out[$];
  bit m_en = 0;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_in_ready", {31'b0, in_ready}, 0);
      chk("rst_out_valid", {31'b0, out_valid}, 0);
      chk("rst_out_last", {31'b0, out_last}, 0);
      chk("rst_out_data", out_data, 0);
      m_en = 0;
      m_fill.delete();
      m_out.delete();
    end else begin
      bit ev, er;
      ev = m_out.size() > 0;
      er = m_en && !ev;
      chk("in_ready", {31'b0, in_ready}, {31'b0, er});
      chk("out_valid", {31'b0, out_valid}, {31'b0, ev});
      chk("out_data", out_data, ev ? m_out[0] : '0);
      chk("out_last", {31'b0, out_last}, {31'b0, ev && m_out.size() == 1});
      if (flush) begin
        m_fill.delete();
        m_out.delete();
      end else if (ev) begin
        if (out_ready) void'(m_out.pop_front());
      end else if (er && in_valid) begin
        m_fill.push_back(in_data);
        if (m_fill.size() == PTS) begin
          for (int k = 0; k < PTS; k++) m_out.push_back(m_fill[rev(k)]);
          m_fill.delete();
        end
      end
      m_en = 1;
    end
  end

  // Stimulus driver
  logic [N-1:0] src_q[$];
  logic [N-1:0] got_q[$];
  bit junk = 0, drove_junk = 0, rdy_mode = 0, prev_last = 0;
  int low_cnt = 0, pat_k = 0, n_acc = 0;
  int order[PTS] = '{0, 4, 2, 6, 1, 5, 3, 7};

  task automatic step();
    bit ai, ao;
    @(negedge clk);
    ai = in_valid && in_ready && !flush && !reset;
    ao = out_valid && out_ready && !flush && !reset;
    if (!in_ready && !reset) low_cnt++;
    if (prev_last && in_valid) chk("accept_after_last", {31'b0, in_ready}, 1);
    if (ao) got_q.push_back(out_data);
    prev_last = ao && out_last;
    @(posedge clk);
    #1;
    if (ai) begin
      n_acc++;
      if (!drove_junk && src_q.size() > 0) void'(src_q.pop_front());
    end
    flush = 0;
    pat_k++;
    out_ready = rdy_mode ? ((pat_k % 4 == 0) || (pat_k % 4 == 3)) : 1'b1;
    if (junk && !in_ready) begin
      in_valid = 1; in_data = 32'hDEADBEEF; drove_junk = 1;
    end else if (src_q.size() > 0) begin
      in_valid = 1; in_data = src_q[0]; drove_junk = 0;
    end else begin
      in_valid = 0; in_data = '0; drove_junk = 0;
    end
  endtask

  task automatic run_out(input int n);
    int budget = 200;
    while (got_q.size() < n && budget > 0) begin
      step();
      budget--;
    end
    if (got_q.size() < n) chk("timeout_out", got_q.size(), n);
  endtask

  task automatic run_acc(input int n);
    int budget = 200;
    while (n_acc < n && budget > 0) begin
      step();
      budget--;
    end
    if (n_acc < n) chk("timeout_acc", n_acc, n);
  endtask

  task automatic load_ramp(input logic [N-1:0] base, input logic [N-1:0] stride);
    for (int k = 0; k < PTS; k++) src_q.push_back(base + stride * k);
  endtask

  task automatic check_ramp(input string name, input logic [N-1:0] base);
    for (int k = 0; k < PTS; k++)
      chk(name, (got_q.size() > k) ? got_q[k] : 32'hXXXXXXXX, base + 32'h00010001 * order[k]);
  endtask

  initial begin
    repeat (3) step();
    #2;
    chk("reset_in_ready", {31'b0, in_ready}, 0);
    chk("reset_out_data", out_data, 0);
    @(posedge clk); #1 reset = 0;
    step();
    chk("ready_after_reset", {31'b0, in_ready}, 1);

    // Natural ramp, no backpressure
    got_q.delete(); low_cnt = 0;
    load_ramp(0, 32'h00010001);
    step();
    run_out(PTS);
    repeat (3) step();
    check_ramp("bitrev_order", 0);
    chk("ready_low_cycles", low_cnt, PTS);

    // Backpressure pattern 1,0,0,1
    got_q.delete(); rdy_mode = 1; pat_k = 0;
    load_ramp(0, 32'h00010001);
    run_out(PTS);
    rdy_mode = 0;
    repeat (2) step();
    check_ramp("backpressure", 0);
    chk("backpressure_count", got_q.size(), PTS);

    // Flush after five accepts
    got_q.delete(); n_acc = 0;
    load_ramp(32'h0F000000, 1);
    run_acc(5);
    src_q.delete();
    in_valid = 1; in_data = 32'h0BAD0BAD; flush = 1;
    step();
    load_ramp(32'h10000000, 1);
    run_out(PTS);
    repeat (2) step();
    for (int k = 0; k < PTS; k++)
      chk("flush_frame", (got_q.size() > k) ? got_q[k] : 32'hXXXXXXXX, 32'h10000000 + order[k]);

    // Drain-time junk input, next frame queued behind
    got_q.delete(); junk = 1;
    load_ramp(32'h20000000, 1);
    load_ramp(32'h30000000, 1);
    run_out(2 * PTS);
    junk = 0;
    repeat (2) step();
    chk("junk_frame_a2", got_q[2], 32'h20000002);
    chk("junk_frame_b0", got_q[PTS], 32'h30000000);
    chk("junk_frame_b1", got_q[PTS+1], 32'h30000004);

    // Signed and boundary values
    got_q.delete();
    src_q.push_back(32'h80008000); src_q.push_back(32'h7FFF7FFF); src_q.push_back(32'hFFFF0001);
    for (int k = 3; k < PTS; k++) src_q.push_back(k);
    run_out(PTS);
    repeat (2) step();
    chk("signed_pos0", got_q[0], 32'h80008000);
    chk("signed_pos4", got_q[4], 32'h7FFF7FFF);
    chk("signed_pos2", got_q[2], 32'hFFFF0001);
    chk("signed_pos1", got_q[1], 32'h00000004);

    // Asynchronous reset mid-drain
    got_q.delete();
    load_ramp(32'h40000000, 1);
    run_out(3);
    #2 reset = 1;
    #1;
    chk("async_out_valid", {31'b0, out_valid}, 0);
    chk("async_out_data", out_data, 0);
    chk("async_in_ready", {31'b0, in_ready}, 0);
    src_q.delete(); in_valid = 0; in_data = '0;
    step();
    @(posedge clk); #1 reset = 0;
    step();
    chk("ready_after_async", {31'b0, in_ready}, 1);
    chk("no_partial_out", got_q.size(), 3);
    got_q.delete();
    load_ramp(0, 32'h00010001);
    run_out(PTS);
    repeat (3) step();
    check_ramp("after_reset_order", 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1);
  end
endmodule

// File: doc/fft_bitrev_loader.md
FFT_BITREV_LOADER -- requirements
Module: fft_bitrev_loader

Interface
REQ-001 Parameter N, default 32: complex word width; real part in [N-1:N/2], imag part in [N/2-1:0], each two's-complement.
REQ-002 Parameter PTS, default 8: FFT frame length in points; it SHALL be a power of two, 2 to 1024.
REQ-003 Parameter LOG2PTS, default 3: SHALL equal log2(PTS); it sets the counter and address width.
REQ-004 clk  input  1: clock; all state SHALL update on the rising edge.
REQ-005 reset  input  1: reset, asynchronous, active-high.
REQ-006 flush  input  1: synchronous frame abort, active-high.
REQ-007 in_valid  input  1: in_data holds a valid sample.
REQ-008 in_ready  output  1: block accepts a sample this cycle.
REQ-009 in_data  input  N: natural-order time-domain sample.
REQ-010 out_valid  output  1: out_data holds a valid bit-reversed sample.
REQ-011 out_ready  input  1: the consumer (butterfly/mac stage input feeder) accepts out_data.
REQ-012 out_data  output  N: sample in bit-reversed order.
REQ-013 out_last  output  1: out_data is the final sample of the frame.

Function
REQ-014 The block SHALL hold a PTS x N register array and run a two-state FSM: FILL and DRAIN.
REQ-015 FILL: in_ready=1, out_valid=0; an input transfer occurs when in_valid && in_ready.
REQ-016 On each input transfer, in_data SHALL be written to mem[bitrev(wr_cnt)], where bitrev reverses the LOG2PTS bits, and wr_cnt SHALL increment.
REQ-017 On the transfer with wr_cnt==PTS-1: wr_cnt SHALL wrap to 0 and the state SHALL become DRAIN on the same edge.
REQ-018 DRAIN: in_ready=0, out_valid=1, out_data=mem[rd_cnt] (combinational read), out_last=(rd_cnt==PTS-1).
REQ-019 An output transfer occurs when out_valid && out_ready; rd_cnt SHALL then increment.
REQ-020 While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable.
REQ-021 On the transfer with rd_cnt==PTS-1: rd_cnt SHALL wrap to 0 and the state SHALL return to FILL on the same edge.
REQ-022 There SHALL be no fill/drain overlap; throughput is one frame per 2*PTS cycles minimum.
REQ-023 In DRAIN, in_valid SHALL be ignored; samples presented there are not stored and counters do not move.
REQ-024 The first sample of a new frame SHALL be accepted in the cycle immediately after the last output transfer.
REQ-025 flush=1 at a rising edge SHALL force the state to FILL and wr_cnt=rd_cnt=0; it SHALL take priority over any simultaneous transfer, which is discarded.
REQ-026 Memory contents SHALL be left unchanged by flush.
REQ-027 out_data SHALL be 0 whenever out_valid=0.
REQ-028 The data path SHALL be a pure move: no arithmetic, rounding or sign change.

Reset
REQ-029 While reset=1: state=FILL, wr_cnt=0, rd_cnt=0, all mem entries=0.
REQ-030 While reset=1: in_ready=0, out_valid=0, out_last=0, out_data=0.
REQ-031 in_ready SHALL first assert in the cycle after reset deasserts.
REQ-032 Reset asserted mid-FILL or mid-DRAIN SHALL abort the frame; no partial output SHALL appear afterwards.

Verification
REQ-033 Bitrev order: PTS=8, out_ready=1, feed 0x00000000..0x00070007 back-to-back -> out_data 0,4,2,6,1,5,3,7 (times 0x00010001), out_last on the 8th, in_ready low for exactly 8 cycles.
REQ-034 Backpressure: out_ready toggled 1,0,0,1,... during DRAIN -> out_data/out_last stable while stalled, same sequence as REQ-033, no sample lost or duplicated.
REQ-035 Flush mid-frame: flush after 5 accepts, then a full 8-sample frame of 0x1000_0000+k -> output is only the new frame, in bit-reversed order.
REQ-036 Drain-time input: hold in_valid=1 throughout DRAIN with data 0xDEADBEEF -> never stored; next frame is accepted starting the cycle after out_last transfers.
REQ-037 Async reset mid-DRAIN: assert reset between clock edges after 3 outputs -> out_valid=0 and out_data=0 immediately; after release, in_ready=1 next cycle and a fresh frame reproduces REQ-033.
REQ-038 Signed/boundary data: frame containing 0x80008000, 0x7FFF7FFF and 0xFFFF0001 -> emitted bit-exact at its bit-reversed positions.
